// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data-memory responder for the CPU MEM stage. One
//            load/store request is accepted at a time over a valid/ready
//            handshake. The access commits on the edge entering RESP and a
//            one-cycle response pulse follows LATENCY cycles after accept.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous active-high reset
//            req_valid_i  - request valid (held until response)
//            req_ready_o  - responder can accept this cycle
//            req_write_i  - 1 = store, 0 = load
//            req_addr_i   - byte address
//            req_wdata_i  - store data
//            req_wstrb_i  - store byte-lane enables
//            resp_valid_o - one-cycle response pulse
//            resp_rdata_o - load data (0 for stores and faults)
//            resp_err_o   - access fault, qualified by resp_valid_o
//            stall_o      - pipeline hold while an access is outstanding
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        stall_o
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [29:0]   C_DEPTH    = 30'(DEPTH_WORDS);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          src_write;
    logic [31:0]   src_addr;
    logic [31:0]   src_wdata;
    logic [3:0]    src_wstrb;
    logic          src_err;
    logic [IW-1:0] src_idx;

    assign req_ready_o  = ~rst_i & (state_q == S_IDLE);
    assign accept       = req_valid_i & req_ready_o;
    assign stall_o      = ~rst_i & (((state_q == S_IDLE) & req_valid_i) | (state_q == S_WAIT));
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    // With LATENCY=1 the commit edge is also the accept edge, so the access
    // must be taken from the live request rather than the capture registers.
    assign src_write = (state_q == S_IDLE) ? req_write_i : write_q;
    assign src_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    assign src_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
    assign src_wstrb = (state_q == S_IDLE) ? req_wstrb_i : wstrb_q;

    assign src_err = (src_addr[1:0] != 2'b00) | (src_addr[31:2] >= C_DEPTH);
    // Only meaningful once src_err is clear; truncation is safe then.
    assign src_idx = src_addr[IW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = C_CNT_LOAD;
                    state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset in WAIT suppresses the commit, aborting the access cleanly.
    assign commit = ~rst_i & (state_d == S_RESP);

    always_comb begin
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (commit) begin
            resp_err_d   = src_err;
            resp_rdata_d = (src_err | src_write) ? 32'h0 : mem[src_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= commit;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
            end
        end
    end

    // Array contents survive reset; only enabled lanes of a good store change.
    always_ff @(posedge clk_i) begin
        if (commit & src_write & ~src_err) begin
            for (int b = 0; b < 4; b++) begin
                if (src_wstrb[b]) begin
                    mem[src_idx][8*b +: 8] <= src_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. A LATENCY=4 instance
//            covers latency, stall, byte lanes, faults and abort-by-reset;
//            a LATENCY=1 instance covers back-to-back held requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, write;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        ready, rvalid, err, stall;
    logic [31:0] rdata;

    logic        valid1, write1;
    logic [31:0] addr1, wdata1;
    logic [3:0]  wstrb1;
    logic        ready1, rvalid1, err1, stall1;
    logic [31:0] rdata1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_ready_o(ready), .req_write_i(write),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_wstrb_i(wstrb),
        .resp_valid_o(rvalid), .resp_rdata_o(rdata), .resp_err_o(err),
        .stall_o(stall)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid1), .req_ready_o(ready1), .req_write_i(write1),
        .req_addr_i(addr1), .req_wdata_i(wdata1), .req_wstrb_i(wstrb1),
        .resp_valid_o(rvalid1), .resp_rdata_o(rdata1), .resp_err_o(err1),
        .stall_o(stall1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the LATENCY=4 instance; request fields are scrambled
    // after the accept edge to show they are no longer sampled.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] exp_rd,
                          input logic exp_err);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        valid = 1'b1; write = wr; addr = a; wdata = wd; wstrb = st;
        #1;
        chk("ready_idle", 32'(ready), 32'd1);
        chk("stall_accept", 32'(stall), 32'd1);
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        addr  = $urandom;
        wdata = $urandom;
        wstrb = 4'($urandom);
        write = ~wr;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rvalid) begin
                seen = 1'b1;
            end else begin
                chk("stall_wait", 32'(stall), 32'd1);
                chk("ready_wait", 32'(ready), 32'd0);
            end
        end
        chk("latency", 32'(cyc), 32'(LAT));
        if (sb.size() > 0) e = sb.pop_front();
        if (seen) begin
            chk("resp_rdata", rdata, e.rdata);
            chk("resp_err", 32'(err), 32'(e.err));
            chk("stall_resp", 32'(stall), 32'd0);
            chk("ready_resp", 32'(ready), 32'd0);
        end
        valid = 1'b0;
        @(negedge clk);
        chk("resp_pulse", 32'(rvalid), 32'd0);
        chk("rdata_hold", rdata, e.rdata);
        chk("ready_after", 32'(ready), 32'd1);
    endtask

    initial begin
        int          seen_cnt;
        exp_t        e;
        logic        t_wr [4];
        logic [31:0] t_ad [4];
        logic [31:0] t_wd [4];
        logic [31:0] t_ex [4];

        rst = 1'b1;
        valid = 1'b1; write = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        valid1 = 1'b0; write1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; wstrb1 = 4'h0;

        // Reset behaviour, with valid asserted to show stall is gated.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", 32'(ready), 32'd1);

        // Store/load and byte-lane merge.
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        access(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        access(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0);
        access(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Faults must not disturb the array.
        access(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        access(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        access(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        access(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        access(1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);

        // Zero-strobe store is a legal no-op.
        access(1'b1, 32'h10, 32'h11111111, 4'h0, 32'h0, 1'b0);
        access(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Abort by reset in WAIT; word 0x20 is first given a known value.
        access(1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        valid = 1'b0;
        seen_cnt = 0;
        @(negedge clk);
        chk("abort_ready_back", 32'(ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (rvalid) seen_cnt++;
            @(negedge clk);
        end
        chk("abort_no_resp", 32'(seen_cnt), 32'd0);
        access(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

        // LATENCY=1: requests held valid back-to-back.
        t_wr[0] = 1'b1; t_ad[0] = 32'h8; t_wd[0] = 32'hA5A50001; t_ex[0] = 32'h0;
        t_wr[1] = 1'b0; t_ad[1] = 32'h8; t_wd[1] = 32'h0;        t_ex[1] = 32'hA5A50001;
        t_wr[2] = 1'b1; t_ad[2] = 32'hC; t_wd[2] = 32'h000000FF; t_ex[2] = 32'h0;
        t_wr[3] = 1'b0; t_ad[3] = 32'hC; t_wd[3] = 32'h0;        t_ex[3] = 32'h000000FF;
        @(negedge clk);
        valid1 = 1'b1; write1 = t_wr[0]; addr1 = t_ad[0]; wdata1 = t_wd[0]; wstrb1 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("l1_ready_idle", 32'(ready1), 32'd1);
            chk("l1_stall_idle", 32'(stall1), 32'd1);
            e.rdata = t_ex[i];
            e.err   = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            chk("l1_rvalid", 32'(rvalid1), 32'd1);
            chk("l1_ready_resp", 32'(ready1), 32'd0);
            chk("l1_stall_resp", 32'(stall1), 32'd0);
            if (sb.size() > 0) e = sb.pop_front();
            chk("l1_rdata", rdata1, e.rdata);
            chk("l1_err", 32'(err1), 32'(e.err));
            if (i < 3) begin
                write1 = t_wr[i+1]; addr1 = t_ad[i+1]; wdata1 = t_wd[i+1];
            end else begin
                valid1 = 1'b0;
            end
            @(negedge clk);
            chk("l1_pulse", 32'(rvalid1), 32'd0);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
